// File: rtl/arbiter4_pipeline.sv
// Four-channel round-robin arbiter feeding one registered valid/ready output stage.
// The grant pointer advances only on an accepted transfer.
module arbiter4_pipeline #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ready_in,
  input  logic [3:0]      valid_in,
  input  logic [4*DW-1:0] data_in,
  output logic [3:0]      ready_out,
  output logic            valid_out,
  output logic [DW-1:0]   data_out
);

  logic [1:0]    last_q, last_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  logic [1:0]    winner;
  logic          found;
  logic          can_load;
  logic          accept;
  logic [DW-1:0] win_word;

  // Search order is last+1, last+2, last+3, last; the 2-bit add wraps naturally.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!found && valid_in[last_q + 2'(k)]) begin
        found  = 1'b1;
        winner = last_q + 2'(k);
      end
    end
  end

  always_comb begin
    win_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (winner == 2'(i)) win_word = data_in[i*DW +: DW];
    end
  end

  assign can_load = ~valid_q | ready_in;
  assign accept   = can_load & found & ~rst;

  always_comb begin
    ready_out = 4'b0000;
    if (accept) ready_out[winner] = 1'b1;
  end

  always_comb begin
    last_d  = last_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      last_d  = winner;
      valid_d = 1'b1;
      data_d  = win_word;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 2'd3;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      last_q  <= last_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_arbiter4_pipeline.sv
// Directed bench for arbiter4_pipeline: literal per-cycle expectations plus a
// rule-level reference model checked against the DUT on every cycle.
module tb_arbiter4_pipeline;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_in;
  logic [3:0]  valid_in;
  logic [31:0] data_in;
  logic [3:0]  ready_out;
  logic        valid_out;
  logic [7:0]  data_out;

  int checks = 0;
  int fails  = 0;
  bit model_on = 1'b0;

  // reference model state
  int         m_last;
  bit         m_valid;
  logic [7:0] m_data;

  arbiter4_pipeline #(.DW(8)) dut (
    .clk(clk), .rst(rst), .ready_in(ready_in), .valid_in(valid_in),
    .data_in(data_in), .ready_out(ready_out), .valid_out(valid_out),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  function automatic int pick(input int last, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] model_ready();
    int w;
    w = pick(m_last, valid_in);
    if (rst || w < 0 || !(!m_valid || ready_in)) return 4'b0000;
    return 4'(1 << w);
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_last = 3; m_valid = 0; m_data = 8'h00;
    end else begin
      w = pick(m_last, valid_in);
      if (w >= 0 && (!m_valid || ready_in)) begin
        m_data  = data_in[w*8 +: 8];
        m_valid = 1;
        m_last  = w;
      end else if (m_valid && ready_in) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      logic [3:0] er;
      er = model_ready();
      checks++;
      if (ready_out !== er) begin
        fails++;
        $display("FAIL model_ready_out t=%0t got=%b want=%b", $time, ready_out, er);
      end
      checks++;
      if (valid_out !== m_valid) begin
        fails++;
        $display("FAIL model_valid_out t=%0t got=%b want=%b", $time, valid_out, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (data_out !== m_data) begin
          fails++;
          $display("FAIL model_data_out t=%0t got=%h want=%h", $time, data_out, m_data);
        end
      end
    end
  end

  // Drive one cycle, check ready_out mid-cycle, then the registered outputs after the edge.
  task automatic step(input string nm, input logic r, input logic rdy,
                      input logic [3:0] v, input logic [31:0] d,
                      input logic [3:0] exp_ro, input logic exp_vo, input logic [7:0] exp_do);
    rst = r; ready_in = rdy; valid_in = v; data_in = d;
    @(negedge clk);
    checks++;
    if (ready_out !== exp_ro) begin
      fails++;
      $display("FAIL %s ready_out got=%b want=%b", nm, ready_out, exp_ro);
    end
    @(posedge clk);
    #1;
    checks++;
    if (valid_out !== exp_vo) begin
      fails++;
      $display("FAIL %s valid_out got=%b want=%b", nm, valid_out, exp_vo);
    end
    checks++;
    if (data_out !== exp_do) begin
      fails++;
      $display("FAIL %s data_out got=%h want=%h", nm, data_out, exp_do);
    end
  endtask

  initial begin
    rst = 1'b1; ready_in = 1'b1; valid_in = 4'b0000; data_in = '0;
    m_last = 3; m_valid = 0; m_data = 8'h00;
    step("reset", 1, 1, 4'b0000, 32'h0, 4'b0000, 0, 8'h00);
    model_on = 1'b1;

    // round-robin sequence
    step("rr0", 0, 1, 4'b0001, 32'h00000001, 4'b0001, 1, 8'h01);
    step("rr1", 0, 1, 4'b0111, 32'h00211102, 4'b0010, 1, 8'h11);
    step("rr2", 0, 1, 4'b0111, 32'h00211202, 4'b0100, 1, 8'h21);
    step("rr3", 0, 1, 4'b0011, 32'h00001202, 4'b0001, 1, 8'h02);
    step("rr4", 0, 1, 4'b1011, 32'h31001203, 4'b0010, 1, 8'h12);
    step("rr5", 0, 1, 4'b1001, 32'h31000003, 4'b1000, 1, 8'h31);

    // fairness: all request, grants rotate 0..3 twice
    for (int n = 0; n < 8; n++) begin
      logic [3:0] ro;
      logic [7:0] dv;
      ro = 4'(1 << (n % 4));
      dv = 8'(8'h11 * ((n % 4) + 1));
      step("fair", 0, 1, 4'b1111, 32'h44332211, ro, 1, dv);
    end

    // backpressure: hold, no grants, pointer frozen at 3
    for (int n = 0; n < 3; n++)
      step("bp_hold", 0, 0, 4'b1111, 32'h55667788, 4'b0000, 1, 8'h44);
    step("bp_resume0", 0, 1, 4'b1111, 32'h44332211, 4'b0001, 1, 8'h11);
    step("bp_resume1", 0, 1, 4'b1111, 32'h44332211, 4'b0010, 1, 8'h22);

    // drain
    step("drain", 0, 1, 4'b0000, 32'h44332211, 4'b0000, 0, 8'h22);
    step("idle", 0, 0, 4'b0000, 32'h44332211, 4'b0000, 0, 8'h22);
    step("load_idle", 0, 0, 4'b0100, 32'h00AB0000, 4'b0100, 1, 8'hAB);

    // mid-run reset drops the word and restores channel 0 priority
    step("midrst", 1, 0, 4'b1111, 32'h44332211, 4'b0000, 0, 8'h00);
    step("post_rst", 0, 1, 4'b1111, 32'h44332211, 4'b0001, 1, 8'h11);

    // single requester is granted every cycle regardless of pointer
    step("single0", 0, 1, 4'b0100, 32'h00330000, 4'b0100, 1, 8'h33);
    step("single1", 0, 1, 4'b0100, 32'h00340000, 4'b0100, 1, 8'h34);
    step("hold_novalid", 0, 0, 4'b0000, 32'h0, 4'b0000, 1, 8'h34);

    // mixed traffic checked by the model only
    for (int n = 0; n < 300; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      ready_in = ($urandom_range(0, 3) != 0);
      valid_in = 4'($urandom);
      data_in  = $urandom;
      @(posedge clk);
      #1;
    end

    model_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
